// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: 3-5 cycles per instruction, plus one cycle per mem_ready=0 in FETCH or MEM.
// Memory stalls hold FETCH/MEM; reset is asynchronous and also gates every enable combinationally.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  wb_src,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  state_t      state_q, state_d;
  logic [4:0]  opcode;
  logic        is_load, is_opimm, is_auipc, is_store, is_op, is_lui;
  logic        is_branch, is_jalr, is_jal, is_alu_wb, legal;
  logic        mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c;
  logic        unused_instr;

  assign opcode       = instr[6:2];
  assign unused_instr = ^instr[31:7];

  assign is_load   = (opcode == OPC_LOAD);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_store  = (opcode == OPC_STORE);
  assign is_op     = (opcode == OPC_OP);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_alu_wb = is_op | is_opimm | is_lui | is_auipc | is_jal | is_jalr;

  assign legal = (instr[1:0] == 2'b11) &&
                 (is_alu_wb | is_load | is_store | is_branch);

  // Datapath selects depend only on the held instruction
  assign alu_a_sel = is_auipc;
  assign alu_b_sel = is_opimm | is_load | is_store | is_jalr | is_auipc;

  always_comb begin
    if (is_load)                wb_src = 2'b01;
    else if (is_jal || is_jalr) wb_src = 2'b10;
    else if (is_lui)            wb_src = 2'b11;
    else                        wb_src = 2'b00;
  end

  always_comb begin
    state_d      = state_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    reg_we_c     = 1'b0;
    mem_addr_sel = 1'b0;
    pc_src       = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_branch) begin
          pc_we_c = 1'b1;
          pc_src  = branch_taken ? 2'b01 : 2'b00;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_alu_wb) begin
          state_d = S_WB;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        mem_req_c    = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we_c     = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        if (is_jal)       pc_src = 2'b01;
        else if (is_jalr) pc_src = 2'b10;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Enables drop as soon as reset rises, not at the next edge
  assign mem_req = mem_req_c & ~reset;
  assign mem_we  = mem_we_c  & ~reset;
  assign ir_we   = ir_we_c   & ~reset;
  assign pc_we   = pc_we_c   & ~reset;
  assign reg_we  = reg_we_c  & ~reset;
  assign state   = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      illegal <= 1'b0;
      instret <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal <= 1'b1;
      if (pc_we)             instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction table plus stall, trap, wrap and reset sequences.
module tb_multicycle_ctrl;

  logic        clk, reset, mem_ready, branch_taken;
  logic [31:0] instr;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
  logic        alu_a_sel, alu_b_sel, illegal;
  logic [1:0]  pc_src, wb_src;
  logic [2:0]  state;
  logic [31:0] instret;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .reg_we(reg_we), .wb_src(wb_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .illegal(illegal), .state(state), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] ins;
    logic        bt;
    int          cycles;
    logic [1:0]  pc_src;
    logic [1:0]  wb_src;
    logic        reg_we;
    logic        mem_we;
    logic        a_sel;
    logic        b_sel;
  } vec_t;

  vec_t vecs [10];

  int          addi_st [4]  = '{0, 1, 2, 4};
  logic        addi_we [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
  int          lw_st   [7]  = '{0, 1, 2, 3, 3, 3, 4};
  logic        lw_rdy  [7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] trap_i  [3]  = '{32'h0000_0000, 32'h0050_0090, 32'h0000_007F};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the FSM in FETCH; returns at the negedge after retirement
  task automatic run_instr(input vec_t v, input int idx);
    int          cyc, n_pc, n_reg;
    logic        done, mw, a, b;
    logic [1:0]  ps, ws;
    logic [31:0] start;
    cyc = 0; n_pc = 0; n_reg = 0; done = 1'b0; mw = 1'b0;
    a = 1'bx; b = 1'bx; ps = 2'bxx; ws = 2'bxx;
    start = instret;
    instr = v.ins; branch_taken = v.bt; mem_ready = 1'b1;
    while (!done && cyc < 20) begin
      #1;
      cyc++;
      if (state == 3'd2) begin a = alu_a_sel; b = alu_b_sel; end
      if (reg_we) n_reg++;
      if (mem_we) mw = 1'b1;
      if (pc_we) begin n_pc++; ps = pc_src; ws = wb_src; done = 1'b1; end
      @(negedge clk);
    end
    check($sformatf("v%0d_cycles", idx), cyc, v.cycles);
    check($sformatf("v%0d_pc_we_count", idx), n_pc, 1);
    check($sformatf("v%0d_pc_src", idx), ps, v.pc_src);
    check($sformatf("v%0d_wb_src", idx), ws, v.wb_src);
    check($sformatf("v%0d_reg_we_count", idx), n_reg, v.reg_we);
    check($sformatf("v%0d_mem_we", idx), mw, v.mem_we);
    check($sformatf("v%0d_alu_a_sel", idx), a, v.a_sel);
    check($sformatf("v%0d_alu_b_sel", idx), b, v.b_sel);
    check($sformatf("v%0d_instret_delta", idx), instret - start, 1);
    check($sformatf("v%0d_back_to_fetch", idx), state, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] snap;
    logic        bad;

    //          instr          bt    cyc pc_src wb_src reg  mem  a     b
    vecs[0] = '{32'h0050_0093, 1'b1, 4, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1}; // addi, bt ignored
    vecs[1] = '{32'h0020_81B3, 1'b0, 4, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0}; // add
    vecs[2] = '{32'h1234_50B7, 1'b0, 4, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0}; // lui
    vecs[3] = '{32'h0000_1097, 1'b0, 4, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1}; // auipc
    vecs[4] = '{32'h0080_00EF, 1'b0, 4, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0}; // jal
    vecs[5] = '{32'h0000_80E7, 1'b1, 4, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1}; // jalr
    vecs[6] = '{32'h0020_A223, 1'b0, 4, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1}; // sw
    vecs[7] = '{32'h0000_A103, 1'b0, 5, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1}; // lw
    vecs[8] = '{32'h0020_8463, 1'b1, 3, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // beq taken
    vecs[9] = '{32'h0020_8463, 1'b0, 3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0}; // beq not taken

    reset = 1'b1; instr = 32'h0; mem_ready = 1'b1; branch_taken = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_illegal", illegal, 0);
    check("rst_instret", instret, 0);
    check("rst_enables", {mem_req, mem_we, ir_we, pc_we, reg_we}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_instr(vecs[i], i);
    check("table_instret", instret, 10);

    // addi state trace
    instr = 32'h0050_0093; mem_ready = 1'b1; branch_taken = 1'b0;
    snap = instret;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("addi_state_c%0d", c), state, addi_st[c]);
      check($sformatf("addi_reg_we_c%0d", c), reg_we, addi_we[c]);
      check($sformatf("addi_pc_we_c%0d", c), pc_we, addi_we[c]);
      @(negedge clk);
    end
    check("addi_end_state", state, 0);
    check("addi_instret", instret, snap + 1);

    // lw with two stall cycles in MEM; mem_ready toggles outside FETCH/MEM are ignored
    instr = 32'h0000_A103;
    snap = instret;
    for (int c = 0; c < 7; c++) begin
      mem_ready = lw_rdy[c];
      #1;
      check($sformatf("lw_state_c%0d", c), state, lw_st[c]);
      if (lw_st[c] == 3) check($sformatf("lw_mem_req_c%0d", c), {mem_req, mem_addr_sel, mem_we}, 3'b110);
      if (c == 6) begin
        check("lw_wb_src", wb_src, 2'b01);
        check("lw_wb_reg_we", reg_we, 1);
      end
      @(negedge clk);
    end
    check("lw_end_state", state, 0);
    check("lw_instret", instret, snap + 1);

    // instret wrap
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    #1;
    check("wrap_preset", instret, 32'hFFFF_FFFF);
    @(negedge clk);
    run_instr(vecs[0], 100);
    check("wrap_instret", instret, 0);
    run_instr(vecs[0], 101);
    check("pre_reset_instret", instret, 1);

    // async reset mid-FETCH with a stalled request
    mem_ready = 1'b0;
    #1;
    check("fetch_stall_req", mem_req, 1);
    check("fetch_stall_ir_we", ir_we, 0);
    @(negedge clk);
    #1;
    check("fetch_stall_hold", state, 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_fetch_req", mem_req, 0);
    check("arst_fetch_state", state, 0);
    check("arst_fetch_instret", instret, 0);
    @(negedge clk);
    reset = 1'b0;

    // async reset mid-MEM of a store, then refetch
    instr = 32'h0020_A223; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("sw_mem_state", state, 3);
    check("sw_mem_ctrl", {mem_req, mem_we, mem_addr_sel}, 3'b111);
    #1;
    reset = 1'b1;
    #1;
    check("arst_mem_req", {mem_req, mem_we}, 2'b00);
    check("arst_mem_state", state, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("post_rst_fetch", {state, mem_req, mem_addr_sel, ir_we}, {3'd0, 1'b1, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    check("post_rst_decode", state, 1);

    // illegal instructions trap after DECODE and stay there
    for (int t = 0; t < 3; t++) begin
      do_reset();
      instr = trap_i[t]; mem_ready = 1'b1; branch_taken = 1'b1;
      #1;
      check($sformatf("trap%0d_fetch", t), state, 0);
      @(negedge clk);
      #1;
      check($sformatf("trap%0d_decode", t), {state, illegal}, {3'd1, 1'b0});
      @(negedge clk);
      #1;
      check($sformatf("trap%0d_state", t), state, 5);
      check($sformatf("trap%0d_illegal", t), illegal, 1);
      snap = instret;
      bad = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        mem_ready = c[0];
        #1;
        if ({mem_req, mem_we, ir_we, pc_we, reg_we} != 5'd0 || state != 3'd5 || illegal != 1'b1)
          bad = 1'b1;
      end
      check($sformatf("trap%0d_quiet_20", t), bad, 0);
      check($sformatf("trap%0d_instret_frozen", t), instret, snap);
      reset = 1'b1;
      #1;
      check($sformatf("trap%0d_rst_clear", t), {state, illegal}, {3'd0, 1'b0});
      @(negedge clk);
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: instr  in  32  current instruction-register contents; opcode = instr[6:2].
REQ-004 SHALL have port: mem_ready  in  1  memory completes the outstanding request this cycle.
REQ-005 SHALL have port: branch_taken  in  1  ALU comparison result for the current branch.
REQ-006 SHALL have ports: mem_req out 1; mem_we out 1; mem_addr_sel out 1 (0=PC, 1=ALU result).
REQ-007 SHALL have ports: ir_we out 1; pc_we out 1; pc_src out 2 (00 PC+4, 01 PC+imm, 10 ALU result & ~1).
REQ-008 SHALL have ports: reg_we out 1; wb_src out 2 (00 ALU, 01 mem data, 10 PC+4, 11 imm).
REQ-009 SHALL have ports: alu_a_sel out 1 (0 rs1, 1 PC); alu_b_sel out 1 (0 rs2, 1 imm).
REQ-010 SHALL have ports: illegal out 1 sticky trap flag; state out 3 debug; instret out 32 retired count.

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to TRAP.
REQ-012 FETCH: mem_req=1, mem_addr_sel=0; on mem_ready, ir_we=1 and go to DECODE; otherwise hold.
REQ-013 DECODE: one cycle; instr[1:0]!=2'b11 or opcode not in {00000,00100,00101,01000,01100,01101,11000,11001,11011} -> TRAP; otherwise -> EXEC.
REQ-014 EXEC: OP, OP-IMM, LUI, AUIPC, JAL, JALR -> WB; LOAD, STORE -> MEM.
REQ-015 EXEC with BRANCH: pc_we=1, pc_src=01 if branch_taken else 00; -> FETCH.
REQ-016 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 only for STORE; hold until mem_ready.
REQ-017 MEM on mem_ready: STORE -> pc_we=1, pc_src=00, -> FETCH; LOAD -> WB.
REQ-018 WB: reg_we=1 for one cycle; pc_we=1; pc_src=01 for JAL, 10 for JALR, else 00; -> FETCH.
REQ-019 wb_src SHALL be 01 LOAD, 10 JAL/JALR, 11 LUI, 00 otherwise.
REQ-020 alu_a_sel=1 only for AUIPC; alu_b_sel=1 for OP-IMM, LOAD, STORE, JALR, AUIPC; both SHALL be combinational from instr, valid in EXEC, MEM, WB.
REQ-021 mem_req, mem_we, ir_we, pc_we and reg_we SHALL be 0 in every state/condition not listed above.
REQ-022 Each instruction SHALL assert pc_we exactly once. instret SHALL increment by 1 on every cycle pc_we=1. It SHALL wrap from 0xFFFFFFFF to 0.
REQ-023 TRAP: all enables 0, illegal=1, state held until reset; instret frozen.
REQ-024 Latency with mem_ready=1: BRANCH 3 cycles; OP/OP-IMM/LUI/AUIPC/JAL/JALR/STORE 4; LOAD 5; each cycle of mem_ready=0 in FETCH/MEM adds 1.
REQ-025 branch_taken SHALL be ignored outside EXEC with a BRANCH opcode. mem_ready SHALL be ignored outside FETCH and MEM.

Reset
REQ-026 On reset assertion, the block SHALL, without waiting for clk, force state=FETCH, illegal=0 and instret=0.
REQ-027 While reset=1, the block SHALL drive every enable output (mem_req, mem_we, ir_we, pc_we, reg_we) to 0.
REQ-028 Reset mid-MEM SHALL drop mem_req in the same cycle; the first post-reset edge with mem_ready=1 SHALL load IR from PC address.

Verification
REQ-029 instr=0x00500093 (addi), mem_ready=1 -> states 0,1,2,4,0; reg_we and pc_we high in cycle 4 only; alu_b_sel=1; instret 0->1.
REQ-030 instr=0x0000A103 (lw), mem_ready low 2 cycles in MEM -> MEM held 3 cycles; WB with wb_src=01; total 7 cycles.
REQ-031 instr=0x00208463 (beq), branch_taken=1 -> pc_we=1, pc_src=01 in EXEC; reg_we never 1; return to FETCH after 3 cycles.
REQ-032 instr=0x00000000 -> TRAP after DECODE; illegal=1; no enable asserted for 20 cycles; reset clears to FETCH, illegal=0.
REQ-033 instret preset to 0xFFFFFFFF by retiring instructions (or forced) plus one addi -> instret=0.
REQ-034 reset pulsed asynchronously mid-FETCH with mem_req=1 -> mem_req=0 before next clk edge; state=0, instret=0.
